// File: rtl/spi_norm_master.sv
// Single-byte SPI mode-0 master with a load/busy handshake and registered outputs.
// Define SPI_NORM_LSB_FIRST_EN to shift LSB first on both mosi and miso.
module spi_norm_master #(
    parameter int DIV_FREQ_BY = 50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       load_data,
    input  logic       miso,
    output logic       mosi,
    output logic       cs,
    output logic       sck,
    output logic       busy,
    output logic [7:0] received_data
);

    localparam int H     = DIV_FREQ_BY / 2;
    localparam int CNT_W = 17;
    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H - 1);

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] half_cnt;
    logic [3:0]       edge_cnt;
    logic [7:0]       tx_q;
    logic [7:0]       rx_q;

    logic       tick;
    logic       accept;
    logic       rise;
    logic       fall;
    logic       last_fall;
    logic       done;
    logic       cs_next;
    logic       sck_next;
    logic       mosi_next;
    logic       busy_next;
    logic       first_bit;
    logic       next_bit;
    logic [7:0] tx_shifted;
    logic [7:0] rx_shifted;

`ifdef SPI_NORM_LSB_FIRST_EN
    assign first_bit  = data[0];
    assign next_bit   = tx_q[1];
    assign tx_shifted = {1'b0, tx_q[7:1]};
    assign rx_shifted = {miso, rx_q[7:1]};
`else
    assign first_bit  = data[7];
    assign next_bit   = tx_q[6];
    assign tx_shifted = {tx_q[6:0], 1'b0};
    assign rx_shifted = {rx_q[6:0], miso};
`endif

    // tick marks the end of each SCK half-period; every sck toggle lands on one
    assign tick      = (state != IDLE) && (half_cnt == H_LAST);
    assign accept    = (state == IDLE) && load_data;
    assign rise      = tick && ((state == SETUP) || ((state == SHIFT) && !sck));
    assign fall      = tick && (state == SHIFT) && sck;
    assign last_fall = fall && (edge_cnt == 4'd15);
    assign done      = tick && (state == HOLD);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            half_cnt      <= '0;
            edge_cnt      <= '0;
            tx_q          <= '0;
            rx_q          <= '0;
            cs            <= 1'b1;
            sck           <= 1'b0;
            mosi          <= 1'b0;
            busy          <= 1'b0;
            received_data <= '0;
        end else begin
            state <= state_next;
            cs    <= cs_next;
            sck   <= sck_next;
            mosi  <= mosi_next;
            busy  <= busy_next;

            if ((state == IDLE) || tick) begin
                half_cnt <= '0;
            end else begin
                half_cnt <= half_cnt + 1'b1;
            end

            if (state == IDLE) begin
                edge_cnt <= '0;
            end else if (rise || fall) begin
                edge_cnt <= edge_cnt + 1'b1;
            end

            if (accept) begin
                tx_q <= data;
                rx_q <= '0;
            end else begin
                if (fall) tx_q <= tx_shifted;
                if (rise) rx_q <= rx_shifted;
            end

            if (done) received_data <= rx_q;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (load_data) state_next = SETUP;
            SETUP:   if (tick)      state_next = SHIFT;
            SHIFT:   if (last_fall) state_next = HOLD;
            HOLD:    if (tick)      state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    always_comb begin
        cs_next   = (state_next == IDLE);
        busy_next = (state_next != IDLE);
        sck_next  = sck;
        mosi_next = mosi;
        if (rise) sck_next = 1'b1;
        if (fall) sck_next = 1'b0;
        if (accept) begin
            mosi_next = first_bit;
        end else if (fall) begin
            mosi_next = last_fall ? 1'b0 : next_bit;
        end
    end

endmodule

// File: tb/tb_spi_norm_master.sv
// Bench for spi_norm_master: DIV_FREQ_BY=50 instance with a slave model, plus a
// DIV_FREQ_BY=2 instance in mosi->miso loopback.
module tb_spi_norm_master;

    localparam int H  = 25;
    localparam int H2 = 1;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data;
    logic       load_data;
    logic       miso;
    logic       mosi;
    logic       cs;
    logic       sck;
    logic       busy;
    logic [7:0] received_data;

    logic [7:0] data2;
    logic       load2;
    logic       miso2;
    logic       mosi2;
    logic       cs2;
    logic       sck2;
    logic       busy2;
    logic [7:0] received_data2;

    logic [7:0] exp_q[$];
    int tests = 0;
    int fails = 0;

    spi_norm_master #(.DIV_FREQ_BY(50)) dut (
        .clk(clk), .rst(rst), .data(data), .load_data(load_data), .miso(miso),
        .mosi(mosi), .cs(cs), .sck(sck), .busy(busy), .received_data(received_data)
    );

    spi_norm_master #(.DIV_FREQ_BY(2)) dut2 (
        .clk(clk), .rst(rst), .data(data2), .load_data(load2), .miso(miso2),
        .mosi(mosi2), .cs(cs2), .sck(sck2), .busy(busy2), .received_data(received_data2)
    );

    assign miso2 = mosi2;

    always #5 clk = ~clk;

    // i-th bit on the wire (0 = first transmitted)
    function automatic logic exp_bit(input logic [7:0] b, input int i);
`ifdef SPI_NORM_LSB_FIRST_EN
        return b[i[2:0]];
`else
        return b[3'd7 - i[2:0]];
`endif
    endfunction

    // slave presents bit i of its byte so the master assembles exactly that byte
    function automatic logic slave_bit(input logic [7:0] b, input int i);
        if (i >= 8) return 1'b0;
        return exp_bit(b, i);
    endfunction

    // Called at the negedge right after acceptance; returns at the negedge where busy reads 0.
    task automatic monitor_transfer(input logic [7:0] tx_exp, input logic [7:0] slave,
                                    input int change_at, input logic [7:0] change_val);
        int   cyc = 0;
        int   busy_cycles = 0;
        int   pulses = 0;
        int   run = 0;
        int   run_bad = 0;
        int   mosi_bad = 0;
        int   cs_bad = 0;
        logic prev = 1'b0;
        logic [7:0] want;
        tests++;
        if (!(busy === 1'b1 && cs === 1'b0 && sck === 1'b0 && mosi === exp_bit(tx_exp, 0))) begin
            fails++;
            $display("FAIL setup: busy=%b cs=%b sck=%b mosi=%b, required 1 0 0 %b",
                     busy, cs, sck, mosi, exp_bit(tx_exp, 0));
        end
        miso = slave_bit(slave, 0);
        while (busy === 1'b1 && cyc < 2000) begin
            busy_cycles++;
            if (cyc == change_at) data = change_val;
            if (cs !== 1'b0) cs_bad++;
            if (sck === prev) begin
                run++;
            end else begin
                if (run != H) run_bad++;
                run = 1;
                if (sck === 1'b1) begin
                    pulses++;
                    if (mosi !== exp_bit(tx_exp, pulses - 1)) mosi_bad++;
                end
            end
            if (pulses == 8 && sck === 1'b0 && mosi !== 1'b0) mosi_bad++;
            prev = sck;
            miso = slave_bit(slave, pulses);
            @(negedge clk);
            cyc++;
        end
        tests++;
        if (cyc >= 2000) begin
            fails++;
            $display("FAIL timeout: busy still %b after %0d cycles, required 0", busy, cyc);
        end
        tests++;
        if (busy_cycles != 17 * H) begin
            fails++;
            $display("FAIL busy_len: got %0d cycles, required %0d", busy_cycles, 17 * H);
        end
        tests++;
        if (pulses != 8 || run_bad != 0 || run != H || prev !== 1'b0) begin
            fails++;
            $display("FAIL sck_shape: pulses=%0d bad_runs=%0d tail=%0d, required 8 0 %0d",
                     pulses, run_bad, run, H);
        end
        tests++;
        if (mosi_bad != 0 || cs_bad != 0) begin
            fails++;
            $display("FAIL mosi_cs: mosi errors %0d cs errors %0d, required 0 0", mosi_bad, cs_bad);
        end
        want = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
        tests++;
        if (cs !== 1'b1 || received_data !== want) begin
            fails++;
            $display("FAIL complete: cs=%b received=%h, required 1 %h", cs, received_data, want);
        end
    endtask

    task automatic test_reset();
        int bad = 0;
        rst = 1'b1; load_data = 1'b0; data = 8'h00; miso = 1'b0;
        load2 = 1'b0; data2 = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if (!(cs === 1'b1 && sck === 1'b0 && mosi === 1'b0 && busy === 1'b0 && received_data === 8'h00)) begin
            fails++;
            $display("FAIL reset: cs=%b sck=%b mosi=%b busy=%b rx=%h, required 1 0 0 0 00",
                     cs, sck, mosi, busy, received_data);
        end
        tests++;
        if (!(cs2 === 1'b1 && sck2 === 1'b0 && busy2 === 1'b0 && received_data2 === 8'h00)) begin
            fails++;
            $display("FAIL reset2: cs=%b sck=%b busy=%b rx=%h, required 1 0 0 00",
                     cs2, sck2, busy2, received_data2);
        end
        for (int i = 0; i < 100; i++) begin
            miso = 1'($urandom_range(0, 1));
            data = 8'($urandom_range(0, 255));
            @(negedge clk);
            if (!(cs === 1'b1 && sck === 1'b0 && mosi === 1'b0 && busy === 1'b0 && received_data === 8'h00)) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL idle_quiet: %0d cycles changed, required 0", bad);
        end
    endtask

    task automatic test_single();
        data = 8'hA5; load_data = 1'b1;
        exp_q.push_back(8'h3C);
        @(negedge clk);
        load_data = 1'b0;
        monitor_transfer(8'hA5, 8'h3C, -1, 8'h00);
        repeat (50) @(negedge clk);
        tests++;
        if (received_data !== 8'h3C || busy !== 1'b0) begin
            fails++;
            $display("FAIL rx_hold: received=%h busy=%b, required 3c 0", received_data, busy);
        end
    endtask

    task automatic test_back_to_back();
        data = 8'hFF; load_data = 1'b1;
        exp_q.push_back(8'h96);
        @(negedge clk);
        monitor_transfer(8'hFF, 8'h96, 100, 8'h00);
        exp_q.push_back(8'h5A);
        @(negedge clk);
        tests++;
        if (busy !== 1'b1 || cs !== 1'b0) begin
            fails++;
            $display("FAIL b2b_restart: busy=%b cs=%b, required 1 0", busy, cs);
        end
        load_data = 1'b0;
        monitor_transfer(8'h00, 8'h5A, -1, 8'h00);
    endtask

    task automatic test_reset_mid();
        data = 8'hC3; load_data = 1'b1;
        @(negedge clk);
        load_data = 1'b0;
        for (int i = 0; i < 200; i++) begin
            miso = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tests++;
        if (!(cs === 1'b1 && sck === 1'b0 && busy === 1'b0 && mosi === 1'b0 && received_data === 8'h00)) begin
            fails++;
            $display("FAIL reset_mid: cs=%b sck=%b busy=%b mosi=%b rx=%h, required 1 0 0 0 00",
                     cs, sck, busy, mosi, received_data);
        end
        @(negedge clk);
        data = 8'h81; load_data = 1'b1;
        exp_q.push_back(8'h42);
        @(negedge clk);
        load_data = 1'b0;
        monitor_transfer(8'h81, 8'h42, -1, 8'h00);
    endtask

    task automatic test_random();
        logic [7:0] d;
        logic [7:0] s;
        for (int n = 0; n < 3; n++) begin
            d = 8'($urandom_range(0, 255));
            s = 8'($urandom_range(0, 255));
            repeat ($urandom_range(1, 5)) @(negedge clk);
            data = d; load_data = 1'b1;
            exp_q.push_back(s);
            @(negedge clk);
            load_data = 1'b0;
            data = ~d;
            monitor_transfer(d, s, -1, 8'h00);
        end
    endtask

    task automatic test_div2();
        int   cyc = 0;
        int   busy_cycles = 0;
        int   toggles = 0;
        logic prev;
        logic [7:0] want;
        data2 = 8'h01; load2 = 1'b1;
        exp_q.push_back(8'h01);
        @(negedge clk);
        load2 = 1'b0;
        data2 = 8'hFE;
        tests++;
        if (busy2 !== 1'b1 || mosi2 !== exp_bit(8'h01, 0)) begin
            fails++;
            $display("FAIL div2_first: busy=%b mosi=%b, required 1 %b", busy2, mosi2, exp_bit(8'h01, 0));
        end
        prev = sck2;
        while (busy2 === 1'b1 && cyc < 100) begin
            busy_cycles++;
            if (sck2 !== prev) toggles++;
            prev = sck2;
            @(negedge clk);
            cyc++;
        end
        tests++;
        if (busy_cycles != 17 * H2 || toggles != 16) begin
            fails++;
            $display("FAIL div2_timing: busy=%0d toggles=%0d, required %0d 16", busy_cycles, toggles, 17 * H2);
        end
        want = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
        tests++;
        if (received_data2 !== want || cs2 !== 1'b1) begin
            fails++;
            $display("FAIL div2_rx: received=%h cs=%b, required %h 1", received_data2, cs2, want);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_reset_mid();
        test_random();
        test_div2();
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d left, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
